// File: rtl/pipe_pkg.sv
// Shared types and constants for the front-end pipeline registers
// (fetch PC, IF/ID and ID/EX).
package pipe_pkg;

  typedef struct packed {
    logic       rf_wr_en;
    logic       dm_wr_en;
    logic       sel_result;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic [1:0] alu_op;
  } ctrl_t;

  // All-zero control: no register write, no memory write, no branch.
  localparam ctrl_t CTRL_NOP = '0;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    ctrl_t       ctrl;
    logic        valid;
  } idex_t;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: synchronous clear (wins over enable) loads
// CLR_VAL, otherwise the register loads i_d when i_en is high.
module pipe_reg #(
  parameter int           W       = 32,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_clr)     r_q <= CLR_VAL;
    else if (i_en) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_front_regs.sv
// Fetch PC, IF/ID and ID/EX registers with stall/flush control.
// Define PIPE_PERF_CNT_EN to add saturating stall/flush event counters.
module pipe_front_regs
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall_F,
  input  logic        i_stall_D,
  input  logic        i_flush_D,
  input  logic        i_flush_E,
  input  logic [31:0] i_pc_next,
  input  logic [31:0] i_instr_F,
  input  logic [4:0]  i_rs1_D,
  input  logic [4:0]  i_rs2_D,
  input  logic [4:0]  i_rd_D,
  input  logic [31:0] i_rd1_D,
  input  logic [31:0] i_rd2_D,
  input  logic [31:0] i_imm_D,
  input  ctrl_t       i_ctrl_D,
  output logic [31:0] o_pc_F,
  output logic [31:0] o_instr_D,
  output logic [31:0] o_pc_D,
  output logic [31:0] o_pc_plus4_D,
  output logic        o_valid_D,
  output logic        o_valid_E,
  output logic [4:0]  o_rs1_E,
  output logic [4:0]  o_rs2_E,
  output logic [4:0]  o_rd_E,
  output logic [31:0] o_rd1_E,
  output logic [31:0] o_rd2_E,
  output logic [31:0] o_imm_E,
  output logic [31:0] o_pc_E,
  output ctrl_t       o_ctrl_E
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_flush_cnt
`endif
);

  localparam ifid_t IFID_CLR = '{instr: NOP_INSTR, pc: 32'h0, pc_plus4: 32'h0, valid: 1'b0};
  localparam idex_t IDEX_CLR = '0;

  logic [31:0] w_pc_F;
  ifid_t       w_ifid_d, w_ifid_q;
  idex_t       w_idex_d, w_idex_q;

  pipe_reg #(.W(32), .CLR_VAL(RESET_PC)) u_pc_reg (
    .i_clk (i_clk),
    .i_en  (~i_stall_F),
    .i_clr (i_rst),
    .i_d   (i_pc_next),
    .o_q   (w_pc_F)
  );

  // A flush also clears the PC fields; they are meaningless once valid=0.
  assign w_ifid_d = '{instr: i_instr_F, pc: w_pc_F, pc_plus4: w_pc_F + 32'd4, valid: 1'b1};

  pipe_reg #(.W($bits(ifid_t)), .CLR_VAL(IFID_CLR)) u_ifid_reg (
    .i_clk (i_clk),
    .i_en  (~i_stall_D),
    .i_clr (i_rst | i_flush_D),
    .i_d   (w_ifid_d),
    .o_q   (w_ifid_q)
  );

  // i_stall_D is ignored here; the hazard unit pairs it with i_flush_E.
  assign w_idex_d = '{rs1: i_rs1_D, rs2: i_rs2_D, rd: i_rd_D,
                      rd1: i_rd1_D, rd2: i_rd2_D, imm: i_imm_D,
                      pc: w_ifid_q.pc, ctrl: i_ctrl_D,
                      valid: w_ifid_q.valid & ~i_flush_D};

  pipe_reg #(.W($bits(idex_t)), .CLR_VAL(IDEX_CLR)) u_idex_reg (
    .i_clk (i_clk),
    .i_en  (1'b1),
    .i_clr (i_rst | i_flush_E),
    .i_d   (w_idex_d),
    .o_q   (w_idex_q)
  );

  assign o_pc_F       = w_pc_F;
  assign o_instr_D    = w_ifid_q.instr;
  assign o_pc_D       = w_ifid_q.pc;
  assign o_pc_plus4_D = w_ifid_q.pc_plus4;
  assign o_valid_D    = w_ifid_q.valid;
  assign o_valid_E    = w_idex_q.valid;
  assign o_rs1_E      = w_idex_q.rs1;
  assign o_rs2_E      = w_idex_q.rs2;
  assign o_rd_E       = w_idex_q.rd;
  assign o_rd1_E      = w_idex_q.rd1;
  assign o_rd2_E      = w_idex_q.rd2;
  assign o_imm_E      = w_idex_q.imm;
  assign o_pc_E       = w_idex_q.pc;
  assign o_ctrl_E     = w_idex_q.ctrl;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cnt <= 32'h0;
      r_flush_cnt <= 32'h0;
    end else begin
      if (i_stall_D && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (i_flush_D && (r_flush_cnt != 32'hFFFF_FFFF)) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: doc/pipe_front_regs.md
PIPE_FRONT_REGS -- requirements
Module: pipe_front_regs

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, the instruction word inserted on a D bubble.
REQ-003 SHALL have i_clk, input, 1, the single clock; every register updates on its rising edge.
REQ-004 SHALL have i_rst, input, 1, the reset; it is synchronous and active-high.
REQ-005 SHALL have i_stall_F / i_stall_D, input, 1 each, the hold requests from the hazard unit.
REQ-006 SHALL have i_flush_D (taken branch) / i_flush_E (bubble request), input, 1 each.
REQ-007 SHALL have i_pc_next, input, 32, the next-PC mux output.
REQ-008 SHALL have i_instr_F, input, 32, the instruction memory read data.
REQ-009 SHALL have i_rs1_D / i_rs2_D / i_rd_D, input, 5 each, the decoded register indices.
REQ-010 SHALL have i_rd1_D / i_rd2_D / i_imm_D, input, 32 each, the register operands and the immediate.
REQ-011 SHALL have i_ctrl_D, input, ctrl_t (8 bits), the decoded control bundle.
REQ-012 SHALL have o_pc_F, output, 32, the fetch PC.
REQ-013 SHALL have o_instr_D / o_pc_D / o_pc_plus4_D, output, 32 each, the IF/ID contents.
REQ-014 SHALL have o_valid_D / o_valid_E, output, 1 each, set when the stage holds a real instruction.
REQ-015 SHALL have o_rs1_E / o_rs2_E / o_rd_E, output, 5 each, the ID/EX indices.
REQ-016 SHALL have o_rd1_E / o_rd2_E / o_imm_E / o_pc_E, output, 32 each, the ID/EX operands and PC.
REQ-017 SHALL have o_ctrl_E, output, ctrl_t, the ID/EX control bundle.
REQ-018 SHALL have o_stall_cnt / o_flush_cnt, output, 32 each, present only under PIPE_PERF_CNT_EN.

Function
REQ-019 SHALL register all outputs; no combinational path from any input to any output.
REQ-020 SHALL update the PC register to i_pc_next every cycle i_stall_F=0, and hold it when i_stall_F=1.
REQ-021 SHALL resolve the IF/ID register by priority: i_flush_D, then i_stall_D, then normal load.
  - i_flush_D: load instr=NOP_INSTR and valid=0.
  - i_stall_D: hold.
  - Normal load: instr=i_instr_F, pc=o_pc_F, pc_plus4=o_pc_F+4 (mod 2^32), valid=1.
REQ-022 SHALL resolve the ID/EX register by priority: i_flush_E, then normal load.
  - i_flush_E: clear ctrl to CTRL_NOP, rd/rs1/rs2 to 0 and valid to 0; data fields are don't-care.
  - Normal load: capture all D inputs, and set valid = o_valid_D & ~i_flush_D.
REQ-023 SHALL ignore i_stall_D on the ID/EX register; a stalled D with i_flush_E=0 loads a duplicate, and the hazard unit always pairs stall_D with flush_E.
REQ-024 SHALL give i_flush_D=1 with i_stall_D=1 a flushed IF/ID, and i_flush_E=1 with a D load a bubble in E.
REQ-025 SHALL give an E bubble ctrl with register-write, memory-write, sel_result and branch all 0.

Reset
REQ-026 SHALL on i_rst=1 at a clock edge set o_pc_F=RESET_PC, o_instr_D=NOP_INSTR, o_pc_D=0, o_pc_plus4_D=0, and both valids to 0.
REQ-027 SHALL on the same edge set o_ctrl_E=CTRL_NOP, all E indices and data to 0, and both counters to 0.
REQ-028 SHALL give i_rst priority over every stall and flush, including mid-stall; the first fetch after release uses RESET_PC.

Configuration
REQ-029 SHALL, with PIPE_PERF_CNT_EN defined, count o_stall_cnt on each non-reset cycle with i_stall_D=1.
REQ-030 SHALL, with PIPE_PERF_CNT_EN defined, count o_flush_cnt on each non-reset cycle with i_flush_D=1; both counters saturate at 32'hFFFF_FFFF.
REQ-031 SHALL, without PIPE_PERF_CNT_EN, omit both counter ports and their logic.

Structure
REQ-032 SHALL place ctrl_t in package pipe_pkg: a packed struct of rf_wr_en, dm_wr_en, sel_result, branch, jump, alu_src and a 2-bit alu_op.
REQ-033 SHALL place CTRL_NOP and the NOP_INSTR default in pipe_pkg.
REQ-034 SHALL build each stage from one generic sub-module pipe_reg: parameterised width, enable, sync clear, clear value.

Verification
REQ-035 SHALL check reset: i_rst=1 for 2 cycles, then i_pc_next=0x4 -> o_pc_F=0x0 during reset, 0x4 one cycle after release, and o_valid_E=0.
REQ-036 SHALL check a load-use stall: i_stall_F=i_stall_D=i_flush_E=1 for 1 cycle with o_pc_F=0x10 -> o_pc_F stays 0x10, o_instr_D unchanged, o_ctrl_E=CTRL_NOP, o_valid_E=0.
REQ-037 SHALL check a branch flush: i_flush_D=1 with i_instr_F=0x00500093 -> o_instr_D=0x00000013, o_valid_D=0, and o_valid_E=0 on the next cycle.
REQ-038 SHALL check simultaneous flush and stall: i_flush_D=1 with i_stall_D=1 -> IF/ID flushed, not held.
REQ-039 SHALL check PC wrap: o_pc_F=0xFFFF_FFFC loaded into D -> o_pc_plus4_D=0x0000_0000.
REQ-040 SHALL check counters (PIPE_PERF_CNT_EN): 5 stall cycles and 3 flush cycles -> o_stall_cnt=5, o_flush_cnt=3; preload 0xFFFF_FFFF plus one stall -> stays 0xFFFF_FFFF.
